axi_llc_line_reader: RTL and testbench
======================================

AXI_LLC_LINE_READER -- requirements
Module: axi_llc_line_reader

Interface
REQ-001 SHALL have parameter Cfg: llc_cfg_t, default all-zero; provides SetAssociativity, IndexLength, BlockSize, NumBlocks.
REQ-002 SHALL have parameter MaxOutstanding: int unsigned, default 2; response credit count and buffer depth, legal range 1..8.
REQ-003 SHALL have parameter UnitId: cache_unit_e, default RChanUnit; tag written into every request.
REQ-004 SHALL have parameters way_inp_t and way_oup_t, default logic; data-way request and response payload types.
REQ-005 SHALL have ports (clock and reset first; one clock; reset synchronous, active-high):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- cmd_way_ind_i  in  SetAssociativity  one-hot way of the line
- cmd_index_i  in  IndexLength  line index
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted
- way_req_o  out  way_inp_t  block read request to the data ways
- way_req_valid_o  out  1  request valid
- way_req_ready_i  in  1  ways accept request
- way_rsp_i  in  way_oup_t  read response from the ways
- way_rsp_valid_i  in  1  response valid
- way_rsp_ready_o  out  1  response accepted
- blk_data_o  out  BlockSize  block data, in block order
- blk_last_o  out  1  last block of the line
- blk_valid_o  out  1  block valid
- blk_ready_i  in  1  consumer accepts block
- busy_o  out  1  a line read is in progress

Function
REQ-006 SHALL implement a 3-state FSM: IDLE, ISSUE, DRAIN.
REQ-007 IDLE: cmd_ready_o=1; on cmd_valid_i, latch way_ind and index, clear the block counter, go to ISSUE next cycle.
REQ-008 ISSUE: way_req_valid_o=1 iff credits>0; request fields: way_ind=latched, line index=latched, block offset=block counter, write-enable=0, cache_unit=UnitId, data/strb=0.
REQ-009 Request handshake (valid & ready) SHALL increment the block counter and decrement credits; the handshake of block NumBlocks-1 moves the FSM to DRAIN.
REQ-010 way_req_valid_o, once asserted, SHALL stay high with stable payload until the handshake (AXI valid/ready rule).
REQ-011 Credit counter SHALL reset to MaxOutstanding, width clog2(MaxOutstanding+1); it returns one credit per block handshake on the output; a simultaneous take and return leaves it unchanged; it never exceeds MaxOutstanding or underflows.
REQ-012 way_rsp_ready_o SHALL be 1 whenever the buffer is not full; credits guarantee a response is never refused in legal operation.
REQ-013 Accepted responses SHALL enter a FIFO of depth MaxOutstanding; blk_data_o = head data, blk_valid_o = not empty; no reordering.
REQ-014 An output counter SHALL count blocks handed out; blk_last_o=1 on the head when counter = NumBlocks-1.
REQ-015 DRAIN: no requests issued; handshake of the last block returns FSM to IDLE with credits = MaxOutstanding and FIFO empty.
REQ-016 cmd_ready_o SHALL be 0 outside IDLE; a new command is accepted at earliest one cycle after the last-block handshake.
REQ-017 busy_o SHALL be 1 in ISSUE and DRAIN.
REQ-018 Latency: first way_req_valid_o one cycle after command accept; a response is visible on blk_valid_o the cycle after its acceptance (registered FIFO, no fall-through).
REQ-019 With MaxOutstanding>=data-way latency+1 and blk_ready_i held high, requests SHALL issue back-to-back, one per cycle.

Reset
REQ-020 When rst_i is high at a clock edge: FSM=IDLE, counters=0, credits=MaxOutstanding, FIFO empty; outputs way_req_valid_o=0, blk_valid_o=0, blk_last_o=0, busy_o=0, cmd_ready_o=1, way_rsp_ready_o=1, payload outputs 0.
REQ-021 Reset mid-line SHALL abandon the line with no further requests issued; the surrounding LLC resets the data ways in the same cycle.

Structure
REQ-022 llc_cfg_t, cache_unit_e, and the way_inp_t/way_oup_t field layout SHALL remain in axi_llc_pkg; the FSM state enum is local.
REQ-023 The response buffer SHALL be one sub-module, axi_llc_line_reader_buf: synchronous active-high reset FIFO with full/empty flags.

Verification (NumBlocks=4, MaxOutstanding=2, way latency 1)
REQ-024 Command way 4'b0100, index 0x1A, all ready -> 4 requests with offsets 0,1,2,3 in 4 consecutive cycles, 4 blocks out, blk_last_o only on the 4th, then IDLE.
REQ-025 blk_ready_i=0 for 10 cycles -> exactly 2 requests issued, then way_req_valid_o=0 until a block is consumed.
REQ-026 way_req_ready_i low 3 cycles on offset 1 -> valid and payload held stable; offset order preserved.
REQ-027 cmd_valid_i pulsed while busy -> cmd_ready_o=0, command ignored; next command accepted one cycle after the last-block handshake.
REQ-028 rst_i asserted after 2 requests -> next cycle IDLE, credits=2, blk_valid_o=0; a fresh command then completes normally.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared LLC types: configuration record, cache unit tags and the data-way
// request/response layouts used between the line reader and the data ways.
package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned IndexLength;
    int unsigned BlockSize;
    int unsigned NumBlocks;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    WChanUnit,
    RChanUnit,
    EvictUnit,
    RefilUnit
  } cache_unit_e;

  // Field capacities of the way payloads; a configuration must fit inside them.
  localparam int unsigned MaxWays         = 16;
  localparam int unsigned MaxIndexLength  = 16;
  localparam int unsigned MaxBlkOffLength = 4;
  localparam int unsigned MaxBlockSize    = 64;

  typedef struct packed {
    cache_unit_e                   cache_unit;
    logic [MaxWays-1:0]            way_ind;
    logic [MaxIndexLength-1:0]     line_addr;
    logic [MaxBlkOffLength-1:0]    blk_offset;
    logic                          we;
    logic [MaxBlockSize-1:0]       data;
    logic [MaxBlockSize/8-1:0]     strb;
  } way_inp_layout_t;

  typedef struct packed {
    cache_unit_e                   cache_unit;
    logic [MaxWays-1:0]            way_ind;
    logic [MaxBlockSize-1:0]       data;
  } way_oup_layout_t;

endpackage

// File: rtl/axi_llc_line_reader_buf.sv
// Registered in-order response buffer; the head appears the cycle after a push.
module axi_llc_line_reader_buf #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 w_push, w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; the count guards every read, so
  // only the pointers and count need a known state.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_llc_line_reader.sv
// Reads one cache line from the data ways block by block; credits bound the
// requests in flight so every response always finds a free buffer slot.
module axi_llc_line_reader
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg            = llc_cfg_t'('0),
  parameter int unsigned MaxOutstanding = 32'd2,
  parameter cache_unit_e UnitId         = RChanUnit,
  parameter type         way_inp_t      = logic,
  parameter type         way_oup_t      = logic
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [Cfg.SetAssociativity-1:0] cmd_way_ind_i,
  input  logic [Cfg.IndexLength-1:0]      cmd_index_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  output way_inp_t                        way_req_o,
  output logic                            way_req_valid_o,
  input  logic                            way_req_ready_i,
  input  way_oup_t                        way_rsp_i,
  input  logic                            way_rsp_valid_i,
  output logic                            way_rsp_ready_o,
  output logic [Cfg.BlockSize-1:0]        blk_data_o,
  output logic                            blk_last_o,
  output logic                            blk_valid_o,
  input  logic                            blk_ready_i,
  output logic                            busy_o
);

  localparam int unsigned BlkCntW = (Cfg.NumBlocks > 1) ? $clog2(Cfg.NumBlocks) : 1;
  localparam int unsigned CredW   = $clog2(MaxOutstanding + 1);
  localparam logic [BlkCntW-1:0] LastBlk = BlkCntW'(Cfg.NumBlocks - 1);
  localparam logic [CredW-1:0]   CredMax = CredW'(MaxOutstanding);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                          r_state, w_state_next;
  logic [Cfg.SetAssociativity-1:0] r_way_ind;
  logic [Cfg.IndexLength-1:0]      r_index;
  logic [BlkCntW-1:0]              r_blk_cnt, r_out_cnt;
  logic [CredW-1:0]                r_credits;
  logic                            w_cmd_hs, w_req_valid, w_req_hs, w_blk_hs, w_out_last;
  logic                            w_buf_full, w_buf_empty;
  logic [Cfg.BlockSize-1:0]        w_head_data;
  way_inp_layout_t                 w_req;
  way_oup_layout_t                 w_rsp;

  assign cmd_ready_o     = (r_state == IDLE);
  assign busy_o          = (r_state != IDLE);
  assign w_cmd_hs        = cmd_ready_o & cmd_valid_i;
  // Credits only shrink on a handshake, so a raised valid can never drop early.
  assign w_req_valid     = (r_state == ISSUE) && (r_credits != '0);
  assign way_req_valid_o = w_req_valid;
  assign w_req_hs        = w_req_valid & way_req_ready_i;
  assign way_rsp_ready_o = ~w_buf_full;
  assign blk_valid_o     = ~w_buf_empty;
  assign w_blk_hs        = blk_valid_o & blk_ready_i;
  assign w_out_last      = (r_out_cnt == LastBlk);
  assign blk_last_o      = blk_valid_o & w_out_last;
  assign blk_data_o      = w_buf_empty ? '0 : w_head_data;
  assign w_rsp           = way_oup_layout_t'(way_rsp_i);
  assign way_req_o       = way_inp_t'(w_req);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    w_req = '0;
    if (w_req_valid) begin
      w_req.cache_unit = UnitId;
      w_req.way_ind    = MaxWays'(r_way_ind);
      w_req.line_addr  = MaxIndexLength'(r_index);
      w_req.blk_offset = MaxBlkOffLength'(r_blk_cnt);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (cmd_valid_i) w_state_next = ISSUE;
      ISSUE:   if (w_req_hs && (r_blk_cnt == LastBlk)) w_state_next = DRAIN;
      DRAIN:   if (w_blk_hs && w_out_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_way_ind <= '0;
      r_index   <= '0;
      r_blk_cnt <= '0;
      r_out_cnt <= '0;
      r_credits <= CredMax;
    end else begin
      r_state <= w_state_next;
      if (w_cmd_hs) begin
        r_way_ind <= cmd_way_ind_i;
        r_index   <= cmd_index_i;
        r_blk_cnt <= '0;
      end else if (w_req_hs) begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end
      if (w_blk_hs) r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
      case ({w_req_hs, w_blk_hs})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  axi_llc_line_reader_buf #(
    .Depth    (MaxOutstanding),
    .DataWidth(Cfg.BlockSize)
  ) i_buf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (way_rsp_valid_i),
    .data_i (w_rsp.data[Cfg.BlockSize-1:0]),
    .pop_i  (blk_ready_i),
    .data_o (w_head_data),
    .full_o (w_buf_full),
    .empty_o(w_buf_empty)
  );

endmodule

// File: tb/tb_axi_llc_line_reader.sv
// Directed bench for axi_llc_line_reader: 4 blocks per line, 2 credits, and a
// data-way model that answers each request in the cycle it is accepted.
module tb_axi_llc_line_reader;
  import axi_llc_pkg::*;

  localparam llc_cfg_t TbCfg = '{SetAssociativity: 4, IndexLength: 8, BlockSize: 64, NumBlocks: 4};

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      cmd_way;
  logic [7:0]      cmd_index;
  logic            cmd_valid, cmd_ready;
  way_inp_layout_t way_req;
  logic            way_req_valid, way_req_ready;
  way_oup_layout_t way_rsp;
  logic            way_rsp_valid, way_rsp_ready;
  logic [63:0]     blk_data;
  logic            blk_last, blk_valid, blk_ready, busy;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned cyc     = 0;

  way_inp_layout_t req_q[$];
  int unsigned     req_cyc_q[$];
  logic [63:0]     blk_q[$];
  logic            blk_last_q[$];
  int unsigned     blk_cyc_q[$];
  int unsigned     acc_cyc_q[$];
  logic [7:0]      acc_idx_q[$];
  logic            stall_prev = 1'b0;
  way_inp_layout_t stall_req;

  axi_llc_line_reader #(
    .Cfg           (TbCfg),
    .MaxOutstanding(2),
    .UnitId        (RChanUnit),
    .way_inp_t     (way_inp_layout_t),
    .way_oup_t     (way_oup_layout_t)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_way_ind_i  (cmd_way),
    .cmd_index_i    (cmd_index),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .way_req_o      (way_req),
    .way_req_valid_o(way_req_valid),
    .way_req_ready_i(way_req_ready),
    .way_rsp_i      (way_rsp),
    .way_rsp_valid_i(way_rsp_valid),
    .way_rsp_ready_o(way_rsp_ready),
    .blk_data_o     (blk_data),
    .blk_last_o     (blk_last),
    .blk_valid_o    (blk_valid),
    .blk_ready_i    (blk_ready),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] exp_data(input logic [7:0] idx, input logic [3:0] off,
                                           input logic [3:0] way);
    return {8'hA5, idx, 4'h0, off, 8'h3C, 24'h0, 4'h0, way};
  endfunction

  // Data-way model: the block content is derived from the request address.
  always_comb begin
    way_rsp            = '0;
    way_rsp.cache_unit = way_req.cache_unit;
    way_rsp.way_ind    = way_req.way_ind;
    way_rsp.data       = exp_data(way_req.line_addr[7:0], way_req.blk_offset, way_req.way_ind[3:0]);
  end
  assign way_rsp_valid = way_req_valid & way_req_ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", way_req_valid, 1'b1);
        check("hold_payload", way_req, stall_req);
      end
      stall_prev = way_req_valid && !way_req_ready;
      stall_req  = way_req;
      if (way_req_valid && way_req_ready) begin
        req_q.push_back(way_req);
        req_cyc_q.push_back(cyc);
      end
      if (blk_valid && blk_ready) begin
        blk_q.push_back(blk_data);
        blk_last_q.push_back(blk_last);
        blk_cyc_q.push_back(cyc);
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc_q.push_back(cyc);
        acc_idx_q.push_back(cmd_index);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_q.delete(); req_cyc_q.delete();
    blk_q.delete(); blk_last_q.delete(); blk_cyc_q.delete();
    acc_cyc_q.delete(); acc_idx_q.delete();
  endtask

  task automatic send_cmd(input logic [3:0] way, input logic [7:0] idx);
    cmd_way   = way;
    cmd_index = idx;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic check_line(input logic [7:0] idx, input logic [3:0] way);
    check("req_count", req_q.size(), 4);
    check("blk_count", blk_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < req_q.size()) begin
        check("req_offset", req_q[k].blk_offset, k);
        check("req_way", req_q[k].way_ind, way);
        check("req_index", req_q[k].line_addr, idx);
        check("req_we", req_q[k].we, 1'b0);
        check("req_unit", req_q[k].cache_unit, RChanUnit);
        check("req_wdata", {req_q[k].data, req_q[k].strb}, 0);
      end
      if (k < blk_q.size()) begin
        check("blk_data", blk_q[k], exp_data(idx, 4'(k), way));
        check("blk_last", blk_last_q[k], k == 3);
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_way = '0; cmd_index = '0; cmd_valid = 1'b0;
    way_req_ready = 1'b1; blk_ready = 1'b1;
    step(3);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req_valid", way_req_valid, 1'b0);
    check("rst_rsp_ready", way_rsp_ready, 1'b1);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_blk_last", blk_last, 1'b0);
    check("rst_req_payload", way_req, 0);
    check("rst_blk_data", blk_data, 0);

    // Plain line read, everything ready: back-to-back requests
    step(1);
    clear_logs();
    send_cmd(4'b0100, 8'h1A);
    wait_idle(40);
    check_line(8'h1A, 4'b0100);
    check("t1_cmd_ready", cmd_ready, 1'b1);
    if (acc_cyc_q.size() == 1 && req_cyc_q.size() == 4 && blk_cyc_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t1_req_cycle", req_cyc_q[k], acc_cyc_q[0] + 1 + k);
        check("t1_blk_cycle", blk_cyc_q[k], acc_cyc_q[0] + 2 + k);
      end
    end else begin
      check("t1_log_sizes", {acc_cyc_q.size(), req_cyc_q.size(), blk_cyc_q.size()}, {32'd1, 32'd4, 32'd4});
    end

    // Consumer stalled: credits cap the requests at two
    step(1);
    clear_logs();
    blk_ready = 1'b0;
    send_cmd(4'b0001, 8'h42);
    step(9);
    @(negedge clk);
    check("t2_stalled_reqs", req_q.size(), 2);
    check("t2_req_valid_low", way_req_valid, 1'b0);
    check("t2_blk_valid", blk_valid, 1'b1);
    step(1);
    blk_ready = 1'b1;
    wait_idle(40);
    check_line(8'h42, 4'b0001);

    // Ways back-pressure offset 1 for three cycles
    step(1);
    clear_logs();
    send_cmd(4'b0010, 8'h9C);
    step(1);
    way_req_ready = 1'b0;
    step(3);
    way_req_ready = 1'b1;
    wait_idle(40);
    check_line(8'h9C, 4'b0010);
    if (acc_cyc_q.size() == 1 && req_cyc_q.size() > 1)
      check("t3_req1_cycle", req_cyc_q[1], acc_cyc_q[0] + 5);
    else
      check("t3_log_sizes", req_cyc_q.size(), 4);

    // Commands while busy are ignored; next one taken right after the last block
    step(1);
    clear_logs();
    send_cmd(4'b0001, 8'h33);
    step(1);
    cmd_way = 4'b1000; cmd_index = 8'h77; cmd_valid = 1'b1;
    @(negedge clk);
    check("t4_busy_cmd_ready", cmd_ready, 1'b0);
    step(1);
    cmd_way = 4'b0010; cmd_index = 8'h55;
    n = 0;
    while (acc_cyc_q.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t4_accepts", acc_cyc_q.size(), 2);
    check_line(8'h33, 4'b0001);
    if (acc_cyc_q.size() == 2 && blk_cyc_q.size() == 4) begin
      check("t4_first_index", acc_idx_q[0], 8'h33);
      check("t4_second_index", acc_idx_q[1], 8'h55);
      check("t4_accept_gap", acc_cyc_q[1], blk_cyc_q[3] + 1);
    end
    clear_logs();
    step(1);
    cmd_valid = 1'b0;
    wait_idle(40);
    check_line(8'h55, 4'b0010);

    // Reset mid-line after two requests, then a fresh line
    step(1);
    clear_logs();
    send_cmd(4'b1000, 8'h0F);
    step(2);
    rst = 1'b1;
    way_req_ready = 1'b0;
    step(1);
    rst = 1'b0;
    way_req_ready = 1'b1;
    @(negedge clk);
    check("t5_reqs_before_rst", req_q.size(), 2);
    check("t5_busy", busy, 1'b0);
    check("t5_cmd_ready", cmd_ready, 1'b1);
    check("t5_blk_valid", blk_valid, 1'b0);
    check("t5_req_valid", way_req_valid, 1'b0);
    step(3);
    @(negedge clk);
    check("t5_no_more_reqs", req_q.size(), 2);
    step(1);
    clear_logs();
    blk_ready = 1'b0;
    send_cmd(4'b0100, 8'h2C);
    step(9);
    @(negedge clk);
    check("t5_credits_restored", req_q.size(), 2);
    step(1);
    blk_ready = 1'b1;
    wait_idle(40);
    check_line(8'h2C, 4'b0100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
